// File: rtl/ad_n_su_dp.sv
// Add/subtract calculator datapath: operand registers, overflow detect, result capture with sticky error.
// Optional build macro AD_N_SU_SAT_EN saturates the captured result on overflow instead of wrapping.
module ad_n_su_dp #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             ld_x,
  input  logic             ld_y,
  input  logic             ld_y2c,
  input  logic             ld_res,
  input  logic             clr,
  output logic [WIDTH-1:0] x_q,
  output logic [WIDTH-1:0] y_q,
  output logic             v,
  output logic [WIDTH-1:0] res,
  output logic             res_vld,
  output logic             err
);

  localparam logic signed [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]        ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic                    ymin;
  logic signed [WIDTH-1:0] x_s;
  logic signed [WIDTH-1:0] y_s;
  logic signed [WIDTH-1:0] sum;
  logic [WIDTH-1:0]        y_neg;
  logic [WIDTH-1:0]        cap_val;
  logic                    any_ld;

  function automatic logic [WIDTH-1:0] sat_res(input logic signed [WIDTH-1:0] s,
                                               input logic                    ovf,
                                               input logic                    x_neg);
    if (!ovf)
      return s;
    return x_neg ? MIN_VAL : MAX_VAL;
  endfunction

  assign x_s    = $signed(x_q);
  assign y_s    = $signed(y_q);
  assign sum    = x_s + y_s;
  assign y_neg  = ~b_in + ONE;
  assign any_ld = ld_x | ld_y | ld_y2c;

  // Negating MIN yields MIN again, so x - MIN overflows exactly when x is non-negative.
  always_comb begin
    v = 1'b0;
    if (ymin)
      v = ~x_s[WIDTH-1];
    else
      v = (x_s[WIDTH-1] == y_s[WIDTH-1]) && (sum[WIDTH-1] != x_s[WIDTH-1]);
  end

  always_comb begin
`ifdef AD_N_SU_SAT_EN
    cap_val = sat_res(sum, v, x_s[WIDTH-1]);
`else
    cap_val = sum;
`endif
  end

  // Operand stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q  <= '0;
      y_q  <= '0;
      ymin <= 1'b0;
    end else begin
      if (ld_x)
        x_q <= a_in;
      if (ld_y2c) begin
        y_q  <= y_neg;
        ymin <= (b_in == MIN_VAL);
      end else if (ld_y) begin
        y_q  <= b_in;
        ymin <= 1'b0;
      end
    end
  end

  // Result stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res     <= '0;
      res_vld <= 1'b0;
      err     <= 1'b0;
    end else if (clr) begin
      res     <= '0;
      res_vld <= 1'b0;
      err     <= 1'b0;
    end else if (ld_res) begin
      res     <= cap_val;
      res_vld <= 1'b1;
      err     <= err | v;
    end else if (any_ld) begin
      res_vld <= 1'b0;
    end
  end

endmodule
